// File: rtl/fc_seq_feeder.sv
// fc_seq_feeder: gathers a 16-pixel vector, then walks the output neurons,
// fetching each weight word and holding the core inputs for its pipeline depth.
module fc_seq_feeder #(
    parameter int N_IN     = 16,
    parameter int PIX_W    = 9,
    parameter int ACC_W    = 13,
    parameter int N_NEURON = 10,
    parameter int FC_LAT   = 10,
    parameter int AW       = $clog2(N_NEURON)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_valid,
    input  logic [PIX_W-1:0]        pix_data,
    output logic                    pix_ready,
    output logic                    w_rd,
    output logic [AW-1:0]           w_addr,
    input  logic [N_IN-1:0]         w_data,
    output logic [N_IN*PIX_W-1:0]   fc_pix,
    output logic [N_IN-1:0]         fc_bw,
    input  logic [ACC_W-1:0]        fc_res,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ACC_W-1:0]        res_data,
    output logic [AW-1:0]           res_idx,
    output logic                    res_last,
    output logic                    busy
);

    localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int HW = $clog2(FC_LAT + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(N_IN - 1);
    localparam logic [AW-1:0] N_LAST   = AW'(N_NEURON - 1);
    localparam logic [HW-1:0] HOLD_END = HW'(FC_LAT);

    typedef enum logic [2:0] {
        LOAD,
        FETCH,
        WAIT_W,
        HOLD,
        OUT
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   neuron;
    logic [HW-1:0]   hold_cnt;
    logic            pix_fire;
    logic            res_fire;

    // Pixels are only taken while collecting a vector; everything else is busy.
    assign pix_ready = (state == LOAD);
    assign busy      = (state != LOAD);
    assign pix_fire  = pix_valid & pix_ready;
    assign res_fire  = res_valid & res_ready;

    // Sequencer: vector load, per-neuron fetch/hold/capture, result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= '0;
            neuron    <= '0;
            hold_cnt  <= '0;
            fc_pix    <= '0;
            fc_bw     <= '0;
            w_rd      <= 1'b0;
            w_addr    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            res_last  <= 1'b0;
        end else begin
            w_rd <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (pix_fire) begin
                        fc_pix[int'(cnt)*PIX_W +: PIX_W] <= pix_data;
                        if (cnt == CNT_LAST) begin
                            cnt    <= '0;
                            neuron <= '0;
                            w_rd   <= 1'b1;
                            w_addr <= '0;
                            state  <= FETCH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FETCH: begin
                    // w_rd was raised on entry and drops here: one-clock strobe
                    state <= WAIT_W;
                end
                WAIT_W: begin
                    fc_bw    <= w_data;
                    hold_cnt <= '0;
                    state    <= HOLD;
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_END) begin
                        res_data  <= fc_res;
                        res_idx   <= neuron;
                        res_last  <= (neuron == N_LAST);
                        res_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (res_fire) begin
                        res_valid <= 1'b0;
                        if (res_last) begin
                            neuron <= '0;
                            state  <= LOAD;
                        end else begin
                            neuron <= neuron + 1'b1;
                            w_addr <= neuron + 1'b1;
                            w_rd   <= 1'b1;
                            state  <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule
